fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage. Owns the program counter and issues word reads to a synchronous program memory with 1-cycle read latency.
- Presents the IF/ID pipeline register (instruction, pc, valid) to decode.
- Handles decode stalls through a 1-entry skid buffer, so no in-flight word is lost or duplicated.
- Handles control-flow redirects (the branch target computed in decode) by squashing every in-flight and buffered instruction.

---
 rtl/fetch_stage.sv | 84 ++++++++
 tb/tb_fetch_stage.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues reads to a 1-cycle-latency program
// memory and presents the IF/ID register to decode, with a 1-entry skid for stalls.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic        if_valid
);

    logic [31:0] fetch_pc;
    logic        pend_q;
    logic [31:0] pend_pc_q;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        issue;
    logic [31:0] redirect_aligned;

    assign redirect_aligned = redirect_pc & ~32'h0000_0003;

    // Holding back the issue while a stalled response is arriving, or while the skid
    // is occupied, is what guarantees the skid can never be asked to take a second word.
    assign issue = !rst && !redirect_valid && !skid_valid && !(stall && pend_q);

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc       <= RESET_PC;
            pend_q         <= 1'b0;
            pend_pc_q      <= '0;
            skid_valid     <= 1'b0;
            skid_instr     <= NOP_INSTR;
            skid_pc        <= '0;
            if_valid       <= 1'b0;
            if_instruction <= NOP_INSTR;
            if_pc          <= '0;
        end else begin
            pend_q <= issue;
            if (issue) begin
                fetch_pc  <= fetch_pc + 32'd4;
                pend_pc_q <= fetch_pc;
            end

            if (redirect_valid) begin
                fetch_pc       <= redirect_aligned;
                skid_valid     <= 1'b0;
                if_valid       <= 1'b0;
                if_instruction <= NOP_INSTR;
            end else if (stall) begin
                if (pend_q) begin
                    skid_valid <= 1'b1;
                    skid_instr <= imem_rdata;
                    skid_pc    <= pend_pc_q;
                end
            end else if (skid_valid) begin
                skid_valid     <= 1'b0;
                if_valid       <= 1'b1;
                if_instruction <= skid_instr;
                if_pc          <= skid_pc;
            end else if (pend_q) begin
                if_valid       <= 1'b1;
                if_instruction <= imem_rdata;
                if_pc          <= pend_pc_q;
            end else begin
                // Bubble keeps the previous if_pc.
                if_valid       <= 1'b0;
                if_instruction <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed latency scenarios plus randomized stall/redirect
// traffic checked against an expected-PC stream model.
module tb_fetch_stage;

    localparam logic [31:0] KEY  = 32'hA5A5_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] if_instruction, if_pc;
    logic        if_valid;

    logic        rst2, stall2, redirect_valid2;
    logic [31:0] redirect_pc2;
    logic        imem_req2;
    logic [31:0] imem_addr2, imem_rdata2;
    logic [31:0] if_instruction2, if_pc2;
    logic        if_valid2;

    int checks = 0;
    int errors = 0;

    // Reference model state: the PC the next delivered instruction must carry.
    logic [31:0] exp_pc = '0;
    logic        mon_en = 1'b0;
    logic        prev_hold = 1'b0;
    logic [64:0] prev_if = '0;
    int          nvalid = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .if_instruction(if_instruction), .if_pc(if_pc),
        .if_valid(if_valid)
    );

    fetch_stage #(.RESET_PC(RPC2), .NOP_INSTR(NOP)) dut2 (
        .clk(clk), .rst(rst2), .stall(stall2), .redirect_valid(redirect_valid2),
        .redirect_pc(redirect_pc2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .if_instruction(if_instruction2), .if_pc(if_pc2),
        .if_valid(if_valid2)
    );

    // Program memories: 1-cycle latency, garbage when not requested.
    always @(posedge clk) begin
        imem_rdata  <= imem_req  ? (imem_addr  ^ KEY) : $urandom;
        imem_rdata2 <= imem_req2 ? (imem_addr2 ^ KEY) : $urandom;
    end

    // Stream monitor: delivered instructions must be strictly sequential between
    // redirects/resets, and IF/ID must hold through a stall.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_hold) begin
                checks++;
                if ({if_valid, if_pc, if_instruction} !== prev_if) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b pc=%h ins=%h, required %h", if_valid, if_pc, if_instruction, prev_if);
                end
            end else if (if_valid === 1'b1) begin
                checks++;
                nvalid++;
                if (if_pc !== exp_pc || if_instruction !== (exp_pc ^ KEY)) begin
                    errors++;
                    $display("FAIL stream_order: got pc=%h ins=%h, required pc=%h ins=%h", if_pc, if_instruction, exp_pc, exp_pc ^ KEY);
                end
                exp_pc = exp_pc + 32'd4;
            end else begin
                checks++;
                if (if_valid !== 1'b0 || if_instruction !== NOP) begin
                    errors++;
                    $display("FAIL bubble_nop: got v=%b ins=%h, required v=0 ins=%h", if_valid, if_instruction, NOP);
                end
            end
            if (!rst && stall && !redirect_valid && dut.pend_q && dut.skid_valid) begin
                errors++;
                $display("FAIL skid_overflow: got second word while skid full, required none");
            end
            prev_hold = stall && !redirect_valid && !rst;
            prev_if   = {if_valid, if_pc, if_instruction};
            if (rst) exp_pc = 32'h0000_0000;
            else if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        rst2 = 1'b1; stall2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = '0;
        repeat (2) tick();
        rst = 1'b0;
        exp_pc = 32'h0000_0000;
        mon_en = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_issue: got req=%b addr=%h, required req=1 addr=0", imem_req, imem_addr);
        end
        checks++;
        if (if_valid !== 1'b0 || if_instruction !== NOP || if_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got v=%b ins=%h pc=%h, required v=0 ins=%h pc=0", if_valid, if_instruction, if_pc, NOP);
        end
        tick();
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_cycle1: got v=%b, required 0", if_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instruction !== (32'(4 * i) ^ KEY)) begin
                errors++;
                $display("FAIL reset_stream: got v=%b pc=%h ins=%h, required v=1 pc=%h", if_valid, if_pc, if_instruction, 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] x;
        tick(); stall = 1'b1; #1;
        x = if_pc;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) begin tick(); stall = 1'b1; #1; end
            checks++;
            if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== x) begin
                errors++;
                $display("FAIL stall_cycle: got req=%b v=%b pc=%h, required req=0 v=1 pc=%h", imem_req, if_valid, if_pc, x);
            end
        end
        tick(); stall = 1'b0; #1;
        checks++;
        if (imem_req !== 1'b0 || if_pc !== x) begin
            errors++;
            $display("FAIL stall_release: got req=%b pc=%h, required req=0 pc=%h", imem_req, if_pc, x);
        end
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== x + 32'd4) begin
            errors++;
            $display("FAIL skid_out: got v=%b pc=%h, required v=1 pc=%h", if_valid, if_pc, x + 32'd4);
        end
        tick();
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL skid_bubble: got v=%b, required 0", if_valid);
        end
        for (int i = 2; i < 4; i++) begin
            tick();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== x + 32'(4 * i)) begin
                errors++;
                $display("FAIL stall_resume: got v=%b pc=%h, required v=1 pc=%h", if_valid, if_pc, x + 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redir_noissue: got req=%b, required 0", imem_req);
        end
        tick(); redirect_valid = 1'b0; #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_t1: got req=%b addr=%h v=%b, required req=1 addr=100 v=0", imem_req, imem_addr, if_valid);
        end
        tick();
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_t2: got v=%b, required 0", if_valid);
        end
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instruction !== (32'h100 ^ KEY)) begin
            errors++;
            $display("FAIL redir_t3: got v=%b pc=%h ins=%h, required v=1 pc=100", if_valid, if_pc, if_instruction);
        end
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h104) begin
            errors++;
            $display("FAIL redir_t4: got v=%b pc=%h, required v=1 pc=104", if_valid, if_pc);
        end
    endtask

    task automatic test_redirect_skid();
        tick(); stall = 1'b1; #1;
        tick(); stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rskid_noissue: got req=%b, required 0", imem_req);
        end
        tick(); stall = 1'b0; redirect_valid = 1'b0; #1;
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL rskid_t1: got v=%b req=%b addr=%h, required v=0 req=1 addr=200", if_valid, imem_req, imem_addr);
        end
        tick();
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL rskid_t2: got v=%b, required 0", if_valid);
        end
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h200) begin
            errors++;
            $display("FAIL rskid_t3: got v=%b pc=%h, required v=1 pc=200", if_valid, if_pc);
        end
    endtask

    task automatic test_align();
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0102; #1;
        tick(); redirect_valid = 1'b0; #1;
        checks++;
        if (imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL align_addr: got %h, required 00000100", imem_addr);
        end
        tick();
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h100) begin
            errors++;
            $display("FAIL align_pc: got v=%b pc=%h, required v=1 pc=100", if_valid, if_pc);
        end
    endtask

    task automatic test_midreset();
        tick(); stall = 1'b1; #1;
        tick(); stall = 1'b1; rst = 1'b1; #1;
        tick(); stall = 1'b0; rst = 1'b0; #1;
        checks++;
        if (if_valid !== 1'b0 || if_instruction !== NOP || if_pc !== 32'h0) begin
            errors++;
            $display("FAIL midrst_state: got v=%b ins=%h pc=%h, required v=0 ins=%h pc=0", if_valid, if_instruction, if_pc, NOP);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL midrst_issue: got req=%b addr=%h, required req=1 addr=0", imem_req, imem_addr);
        end
        tick();
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_c1: got v=%b, required 0", if_valid);
        end
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
            errors++;
            $display("FAIL midrst_c2: got v=%b pc=%h, required v=1 pc=0", if_valid, if_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want;
        tick(); rst2 = 1'b0; #1;
        checks++;
        if (imem_req2 !== 1'b1 || imem_addr2 !== RPC2) begin
            errors++;
            $display("FAIL wrap_issue: got req=%b addr=%h, required req=1 addr=%h", imem_req2, imem_addr2, RPC2);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            want = RPC2 + 32'(4 * i);
            checks++;
            if (if_valid2 !== 1'b1 || if_pc2 !== want || if_instruction2 !== (want ^ KEY)) begin
                errors++;
                $display("FAIL wrap_pc: got v=%b pc=%h ins=%h, required v=1 pc=%h", if_valid2, if_pc2, if_instruction2, want);
            end
        end
    endtask

    task automatic test_random();
        int start;
        start = nvalid;
        for (int c = 0; c < 3000; c++) begin
            tick();
            stall          = ($urandom_range(0, 9) < 3);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
        end
        tick(); stall = 1'b0; redirect_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (nvalid - start < 600) begin
            errors++;
            $display("FAIL random_throughput: got %0d instructions, required at least 600", nvalid - start);
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_skid();
        test_align();
        test_midreset();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
